// File: rtl/matrix_pkg.sv
// matrix_pkg: shared constants, error codes and parser state encoding for the matrix text parser
package matrix_pkg;
    localparam int MAX_DIM   = 5;
    localparam int MAX_ELEMS = 25;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_9  = 8'h39;
    localparam logic [7:0] ASCII_SP = 8'h20;
    localparam logic [7:0] ASCII_CR = 8'h0d;
    localparam logic [7:0] ASCII_LF = 8'h0a;
    typedef enum logic [1:0] {ERR_NONE, ERR_DIM, ERR_OVF, ERR_CHAR} err_t;
    typedef enum logic [2:0] {S_IDLE, S_GET_ROW, S_GET_COL, S_GET_ELEM, S_WRITE, S_COMMIT} state_t;
endpackage

// File: rtl/matrix_input_parser_if.sv
// matrix_input_parser_if: UART byte stream in, element write burst and commit out
interface matrix_input_parser_if #(
    parameter int DATA_WIDTH = 9
);
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  wr_en;
    logic                  wr_ready;
    logic [2:0]            wr_row;
    logic [2:0]            wr_col;
    logic [4:0]            wr_idx;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  commit;
    modport master (
        input  rx_data, rx_valid, wr_ready,
        output wr_en, wr_row, wr_col, wr_idx, wr_data, commit
    );
    modport slave (
        output rx_data, rx_valid, wr_ready,
        input  wr_en, wr_row, wr_col, wr_idx, wr_data, commit
    );
endinterface

// File: rtl/decimal_token_accumulator.sv
// decimal_token_accumulator: running decimal value of one token with sticky, saturating overflow
module decimal_token_accumulator #(
    parameter int DATA_WIDTH = 9,
    parameter int ELEM_MAX   = 511
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  digit_i,
    input  logic                  clr_i,
    input  logic [3:0]            digit_val_i,
    output logic [DATA_WIDTH-1:0] acc_o,
    output logic                  ovf_o
);
    localparam int WW = DATA_WIDTH + 4;
    localparam logic [WW-1:0] LIMIT = WW'(ELEM_MAX);
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic                  ovf_q, ovf_d;
    logic [WW-1:0]         prod;
    always_comb begin
        prod  = {4'b0, acc_q} * WW'(10) + {{(WW-4){1'b0}}, digit_val_i};
        acc_d = clr_i ? '0 : !digit_i ? acc_q : prod > LIMIT ? DATA_WIDTH'(ELEM_MAX) : prod[DATA_WIDTH-1:0];
        ovf_d = !clr_i && (ovf_q || (digit_i && prod > LIMIT));
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end
    assign acc_o = acc_q;
    assign ovf_o = ovf_q;
endmodule

// File: rtl/matrix_input_parser.sv
// matrix_input_parser: parses "m n e0 .. e(m*n-1)" ASCII text, buffers and validates it,
// then bursts the elements out and commits only when the whole matrix was legal
module matrix_input_parser #(
    parameter int DATA_WIDTH = 9,
    parameter int MAX_DIM    = matrix_pkg::MAX_DIM,
    parameter int ELEM_MAX   = 511
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [1:0]             err_code,
    matrix_input_parser_if.master  bus
);
    import matrix_pkg::*;
    state_t                state_q, state_d;
    err_t                  code_q, code_d;
    logic [2:0]            rows_q, rows_d, cols_q, cols_d;
    logic [4:0]            cnt_q, cnt_d, idx_q, idx_d, total;
    logic                  err_q, err_d, tok_q, tok_d;
    logic [DATA_WIDTH-1:0] buf_q [MAX_ELEMS];
    logic [DATA_WIDTH-1:0] acc;
    logic                  ovf, in_get, is_digit, is_sep, bad_char, tok_end, dim_ok, store, wr_en;
    assign in_get   = state_q inside {S_GET_ROW, S_GET_COL, S_GET_ELEM};
    assign is_digit = bus.rx_data >= ASCII_0 && bus.rx_data <= ASCII_9;
    assign is_sep   = bus.rx_data inside {ASCII_SP, ASCII_CR, ASCII_LF};
    assign bad_char = in_get && bus.rx_valid && !is_digit && !is_sep;
    // a separator only ends a token when at least one digit preceded it
    assign tok_end  = in_get && bus.rx_valid && is_sep && tok_q;
    assign dim_ok   = !ovf && acc != '0 && acc <= DATA_WIDTH'(MAX_DIM);
    assign total    = {2'b0, rows_q} * {2'b0, cols_q};
    decimal_token_accumulator #(.DATA_WIDTH(DATA_WIDTH), .ELEM_MAX(ELEM_MAX)) u_acc (
        .clk         (clk),
        .rst         (rst),
        .digit_i     (in_get && bus.rx_valid && is_digit),
        .clr_i       (tok_end || state_q == S_IDLE),
        .digit_val_i (bus.rx_data[3:0]),
        .acc_o       (acc),
        .ovf_o       (ovf)
    );
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        rows_d  = rows_q;
        cols_d  = cols_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        err_d   = 1'b0;
        store   = 1'b0;
        tok_d   = in_get && (bus.rx_valid ? is_digit : tok_q);
        case (state_q)
            S_IDLE: if (start) begin
                state_d = S_GET_ROW;
                code_d  = ERR_NONE;
                cnt_d   = '0;
                idx_d   = '0;
            end
            S_GET_ROW, S_GET_COL: if (bad_char || (tok_end && !dim_ok)) begin
                state_d = S_IDLE;
                err_d   = 1'b1;
                code_d  = bad_char ? ERR_CHAR : ERR_DIM;
            end else if (tok_end) begin
                state_d = state_q == S_GET_ROW ? S_GET_COL : S_GET_ELEM;
                rows_d  = state_q == S_GET_ROW ? acc[2:0] : rows_q;
                cols_d  = state_q == S_GET_COL ? acc[2:0] : cols_q;
            end
            S_GET_ELEM: if (bad_char || (tok_end && ovf)) begin
                state_d = S_IDLE;
                err_d   = 1'b1;
                code_d  = bad_char ? ERR_CHAR : ERR_OVF;
            end else if (tok_end) begin
                store   = 1'b1;
                cnt_d   = cnt_q + 5'd1;
                state_d = cnt_d == total ? S_WRITE : S_GET_ELEM;
            end
            S_WRITE: if (bus.wr_ready) begin
                state_d = idx_q == total - 5'd1 ? S_COMMIT : S_WRITE;
                idx_d   = idx_q == total - 5'd1 ? idx_q : idx_q + 5'd1;
            end
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            code_q  <= ERR_NONE;
            rows_q  <= '0;
            cols_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            tok_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            rows_q  <= rows_d;
            cols_q  <= cols_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            tok_q   <= tok_d;
        end
    end
    always_ff @(posedge clk) begin
        if (store) buf_q[cnt_q] <= acc;
    end
    assign wr_en       = state_q == S_WRITE;
    assign busy        = state_q != S_IDLE;
    assign done        = state_q == S_COMMIT;
    assign err         = err_q;
    assign err_code    = code_q;
    assign bus.wr_en   = wr_en;
    assign bus.commit  = state_q == S_COMMIT;
    assign bus.wr_row  = rows_q;
    assign bus.wr_col  = cols_q;
    assign bus.wr_idx  = idx_q;
    assign bus.wr_data = wr_en ? buf_q[idx_q] : '0;
endmodule
